// File: rtl/clint_tmr.sv
// ----------------------------------------------------------------------------
// clint_tmr: core-local interruptor for a single hart.
//
// Holds the 64-bit mtime counter, the mtimecmp compare register and the msip
// software-interrupt bit, and drives the registered interrupt lines that the
// write-back unit synchronises into its CSR file.
//
// Register port handshake: a request is accepted on a clock edge where
// req_valid && req_ready; the register access happens on that same edge and
// the response is presented on rsp_valid the following cycle. The response
// (rsp_rdata, rsp_err) is held stable until the edge where
// rsp_valid && rsp_ready, after which req_ready returns high. Only one request
// is ever outstanding.
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake
//   req_wen                 1 = write, 0 = read
//   req_addr[15:0]          byte offset inside the CLINT window
//   req_wdata[63:0]         write data, lane-aligned to the 8-byte word
//   req_wstrb[7:0]          byte enables for writes
//   rsp_valid / rsp_ready   response handshake
//   rsp_rdata[63:0]         read data (0 on writes and errors)
//   rsp_err                 access fault (misaligned or unmapped)
//   mtip_asyn               machine timer interrupt pending
//   msip_asyn               machine software interrupt pending
// ----------------------------------------------------------------------------
module clint_tmr #(
    parameter int TICK_DIV = 1,
    parameter int MHARTID  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mtip_asyn,
    output logic        msip_asyn
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [15:0] MSIP_OFF  = 16'(4 * MHARTID);
    localparam logic [15:0] CMP_OFF   = 16'(16'h4000 + 8 * MHARTID);
    localparam logic [15:0] MTIME_OFF = 16'hBFF8;
    localparam logic [15:0] DIV_LAST  = 16'(TICK_DIV - 1);
    // Odd hart indices place their msip word in the upper half of the
    // 8-byte word, so the writable bit sits at bit 32 instead of bit 0.
    localparam int          MSIP_BIT  = MSIP_OFF[2] ? 32 : 0;
    localparam int          MSIP_BYTE = MSIP_BIT / 8;

    state_t      state;
    state_t      state_next;

    logic [15:0] prescaler;
    logic [15:0] prescaler_next;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp;
    logic [63:0] mtimecmp_next;
    logic        msip;
    logic        msip_next;

    logic        accept;
    logic        hit_msip;
    logic        hit_cmp;
    logic        hit_mtime;
    logic        acc_err;
    logic        wr_ok;
    logic [63:0] rdata_sel;

    logic [63:0] rdata_q;
    logic        err_q;
    logic        mtip_q;
    logic        msip_q;

    function automatic logic [63:0] merge_bytes(
        input logic [63:0] old_val,
        input logic [63:0] wdata,
        input logic [7:0]  wstrb
    );
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Address decode and read mux (evaluated on the acceptance edge)
    // ------------------------------------------------------------------
    always_comb begin
        accept    = req_valid && (state == IDLE);
        hit_msip  = (req_addr[15:3] == MSIP_OFF[15:3]);
        hit_cmp   = (req_addr[15:3] == CMP_OFF[15:3]);
        hit_mtime = (req_addr[15:3] == MTIME_OFF[15:3]);
        acc_err   = (req_addr[2:0] != 3'b000) || !(hit_msip || hit_cmp || hit_mtime);
        wr_ok     = accept && req_wen && !acc_err;

        rdata_sel = 64'd0;
        if (!acc_err && !req_wen) begin
            if (hit_msip) begin
                rdata_sel = 64'(msip) << MSIP_BIT;
            end else if (hit_cmp) begin
                rdata_sel = mtimecmp;
            end else begin
                rdata_sel = mtime;
            end
        end
    end

    // ------------------------------------------------------------------
    // Timebase and register updates
    // ------------------------------------------------------------------
    always_comb begin
        tick           = (prescaler == DIV_LAST);
        prescaler_next = tick ? 16'd0 : prescaler + 16'd1;

        // A bus write to mtime replaces the whole next value: written bytes
        // take the new data, unwritten bytes keep the old (unincremented)
        // value. A zero-strobe write leaves the tick untouched.
        mtime_next = tick ? mtime + 64'd1 : mtime;
        if (wr_ok && hit_mtime && (req_wstrb != 8'd0)) begin
            mtime_next = merge_bytes(mtime, req_wdata, req_wstrb);
        end

        mtimecmp_next = mtimecmp;
        if (wr_ok && hit_cmp) begin
            mtimecmp_next = merge_bytes(mtimecmp, req_wdata, req_wstrb);
        end

        msip_next = msip;
        if (wr_ok && hit_msip && req_wstrb[MSIP_BYTE]) begin
            msip_next = req_wdata[MSIP_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= 16'd0;
            mtime     <= 64'd0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip      <= 1'b0;
            mtip_q    <= 1'b0;
            msip_q    <= 1'b0;
        end else begin
            prescaler <= prescaler_next;
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            msip      <= msip_next;
            // Compare on post-update values so the line reflects the
            // registers as they stand after this edge.
            mtip_q    <= (mtime_next >= mtimecmp_next);
            msip_q    <= msip;
        end
    end

    // ------------------------------------------------------------------
    // Response capture: only loaded on acceptance, held through RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= rdata_sel;
            err_q   <= acc_err;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        mtip_asyn = mtip_q;
        msip_asyn = msip_q;
    end

endmodule

// File: tb/tb_clint_tmr.sv
// ----------------------------------------------------------------------------
// tb_clint_tmr: directed bench for clint_tmr.
// Two instances share one request bus: dut (TICK_DIV=1) and dut4 (TICK_DIV=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_clint_tmr;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_wen;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_ready;

  logic        req_ready,   req_ready_4;
  logic        rsp_valid,   rsp_valid_4;
  logic [63:0] rsp_rdata,   rsp_rdata_4;
  logic        rsp_err,     rsp_err_4;
  logic        mtip_asyn,   mtip_asyn_4;
  logic        msip_asyn,   msip_asyn_4;

  int n_asserts = 0;
  int n_fail    = 0;
  int edges;

  clint_tmr #(.TICK_DIV(1), .MHARTID(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mtip_asyn(mtip_asyn), .msip_asyn(msip_asyn)
  );

  clint_tmr #(.TICK_DIV(4), .MHARTID(0)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_4), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_4),
    .rsp_err(rsp_err_4), .mtip_asyn(mtip_asyn_4), .msip_asyn(msip_asyn_4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // number of rising edges seen since reset was released
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; entered and left just after a falling edge.
  task automatic xfer(input logic wen, input logic [15:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wstrb,
                      output logic [63:0] rd, output logic [63:0] rd4,
                      output logic er, output logic mtip1, output logic msip1,
                      output int acc);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    acc       = edges;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_wdata = 64'd0;
    req_wstrb = 8'd0;
    chk("rsp_valid_latency", rsp_valid, 1'b1);
    chk("rsp_valid_latency_div4", rsp_valid_4, 1'b1);
    rd    = rsp_rdata;
    rd4   = rsp_rdata_4;
    er    = rsp_err;
    mtip1 = mtip_asyn;
    msip1 = msip_asyn;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic wait_edges(input int target);
    int guard;
    guard = 0;
    while (edges != target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (edges != target) begin
      n_asserts++;
      n_fail++;
      $display("FAIL wait_edges: observed %0d expected %0d", edges, target);
    end
  endtask

  initial begin
    logic [63:0] rd, rd4;
    logic        er, m1, s1;
    int          acc, w;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 16'd0;
    req_wdata = 64'd0;
    req_wstrb = 8'd0;
    rsp_ready = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mtip", mtip_asyn, 1'b0);
    chk("rst_msip", msip_asyn, 1'b0);
    rst_n = 1'b1;

    // first IDLE cycle: mtime and mtimecmp reset values
    xfer(1'b0, 16'hBFF8, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("mtime_first_read", rd, 64'd0);
    chk("mtime_first_read_err", er, 1'b0);
    xfer(1'b0, 16'h4000, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("mtimecmp_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mtip_after_reset", mtip_asyn, 1'b0);

    // prescaler: 40 edges -> 40 ticks at div 1, 10 ticks at div 4
    wait_edges(40);
    xfer(1'b0, 16'hBFF8, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("mtime_div1_40", rd, 64'd40);
    chk("mtime_div4_40", rd4, 64'd10);

    // timer interrupt: mtime := 0, mtimecmp := 20
    xfer(1'b1, 16'hBFF8, 64'd0, 8'hFF, rd, rd4, er, m1, s1, acc);
    chk("write_rdata_zero", rd, 64'd0);
    w = acc + 1;
    xfer(1'b1, 16'h4000, 64'd20, 8'hFF, rd, rd4, er, m1, s1, acc);
    chk("mtip_low_after_cmp_write", m1, 1'b0);
    wait_edges(w + 19);
    chk("mtip_mtime19", mtip_asyn, 1'b0);
    @(negedge clk);
    chk("mtip_mtime20", mtip_asyn, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("mtip_level_held", mtip_asyn, 1'b1);
    xfer(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, rd4, er, m1, s1, acc);
    chk("mtip_clear_next_cycle", m1, 1'b0);

    // software interrupt
    xfer(1'b1, 16'h0000, 64'd3, 8'h01, rd, rd4, er, m1, s1, acc);
    chk("msip_not_yet", s1, 1'b0);
    chk("msip_set", msip_asyn, 1'b1);
    xfer(1'b0, 16'h0000, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("msip_readback_1", rd, 64'd1);
    xfer(1'b1, 16'h0000, 64'd0, 8'h00, rd, rd4, er, m1, s1, acc);
    chk("wstrb0_no_err", er, 1'b0);
    xfer(1'b0, 16'h0000, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("wstrb0_no_effect", rd, 64'd1);
    xfer(1'b1, 16'h0000, 64'd0, 8'h01, rd, rd4, er, m1, s1, acc);
    chk("msip_clear", msip_asyn, 1'b0);
    xfer(1'b0, 16'h0000, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("msip_readback_0", rd, 64'd0);

    // byte merge: upper half only
    xfer(1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'hF0, rd, rd4, er, m1, s1, acc);
    xfer(1'b0, 16'h4000, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("cmp_upper_merge", rd, 64'h1122_3344_FFFF_FFFF);

    // write wins over tick, then wrap; mtimecmp=0 keeps mtip high
    xfer(1'b1, 16'h4000, 64'd0, 8'hFF, rd, rd4, er, m1, s1, acc);
    chk("mtip_cmp0", m1, 1'b1);
    xfer(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, rd4, er, m1, s1, acc);
    chk("mtip_cmp0_at_write", m1, 1'b1);
    xfer(1'b0, 16'hBFF8, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("mtime_write_won", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    xfer(1'b0, 16'hBFF8, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("mtime_wrapped", rd, 64'd1);
    chk("mtip_cmp0_after_wrap", mtip_asyn, 1'b1);

    // errors
    xfer(1'b0, 16'h0004, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("misaligned_err", er, 1'b1);
    chk("misaligned_rdata", rd, 64'd0);
    xfer(1'b1, 16'h4004, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, rd4, er, m1, s1, acc);
    chk("misaligned_write_err", er, 1'b1);
    xfer(1'b0, 16'h4000, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("misaligned_no_change", rd, 64'd0);
    chk("misaligned_no_change_err", er, 1'b0);
    xfer(1'b0, 16'h2000, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("unmapped_err", er, 1'b1);
    chk("unmapped_rdata", rd, 64'd0);
    xfer(1'b1, 16'h0008, 64'd1, 8'hFF, rd, rd4, er, m1, s1, acc);
    chk("unmapped_write_err", er, 1'b1);
    xfer(1'b0, 16'h0000, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("unmapped_no_change", rd, 64'd0);

    // back-pressure: response held for 5 cycles
    xfer(1'b1, 16'h4000, 64'hA5A5_0000_1234_5678, 8'hFF, rd, rd4, er, m1, s1, acc);
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 16'h4000;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_rdata", rsp_rdata, 64'hA5A5_0000_1234_5678);
      chk("hold_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hold_released_valid", rsp_valid, 1'b0);
    chk("hold_released_ready", req_ready, 1'b1);

    // reset during RESP drops the response at once
    req_valid = 1'b1;
    req_addr  = 16'h4000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_reset_rsp_valid", rsp_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", rsp_valid, 1'b0);
    chk("midreset_rsp_rdata", rsp_rdata, 64'd0);
    chk("midreset_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, 16'hBFF8, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("post_reset_mtime", rd, 64'd0);
    xfer(1'b0, 16'h4000, 64'd0, 8'd0, rd, rd4, er, m1, s1, acc);
    chk("post_reset_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("post_reset_mtip", mtip_asyn, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/clint_tmr.md
Name: clint_tmr

Overview:
- Core-local interruptor (CLINT) for one hart.
- Owns the 64-bit mtime counter, the mtimecmp compare register and the msip software-interrupt bit.
- Drives the machine timer and software interrupt lines (mtip_asyn, msip_asyn) that the write-back unit synchronises and feeds into its CSR file.
- Sits on the uncached MMIO side of the LSU and is accessed through a single-outstanding request/response register port.

Parameters:
- TICK_DIV, 1: clk cycles per mtime increment; legal range 1..65535.
- MHARTID, 0: hart index served; reported only through the msip/mtimecmp offsets (fixed offsets for hart 0; any other MHARTID adds 8*MHARTID to the mtimecmp offset and 4*MHARTID to the msip offset).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  register request valid
- req_ready  out  1  block accepts a request this cycle
- req_wen  in  1  1=write, 0=read
- req_addr  in  16  byte offset inside the CLINT window
- req_wdata  in  64  write data, lane-aligned to the 8-byte word
- req_wstrb  in  8  byte enables for writes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  requester accepts the response
- rsp_rdata  out  64  read data; 0 on writes and on errors
- rsp_err  out  1  access fault (unmapped or misaligned)
- mtip_asyn  out  1  machine timer interrupt pending
- msip_asyn  out  1  machine software interrupt pending

Behaviour:
- Reset: the asynchronous assertion of rst_n sets the following values immediately.
  - mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0.
  - FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mtip_asyn=0, msip_asyn=0.
  - A reset mid-transaction drops the pending response silently.
- Register map, 8-byte words, word address = req_addr[15:3]:
  - msip at 0x0000: bit0 is writable; bits 63:1 read 0 and ignore writes.
  - mtimecmp at 0x4000.
  - mtime at 0xBFF8.
  - For a 32-bit access, the requester selects the upper half via req_wstrb/lane.
- Errors:
  - req_addr[2:0]!=0 gives rsp_err=1.
  - An unmapped address gives rsp_err=1.
  - When rsp_err=1, no state changes and rsp_rdata=0.
- Writes: byte-granular merge. For each i with req_wstrb[i]=1, reg[8i+7:8i] = req_wdata[8i+7:8i]. A write with req_wstrb=0 completes with no effect and no error.
- FSM has two states, IDLE and RESP.
  - IDLE: req_ready=1. When req_valid=1, the request is accepted at the clock edge, the register access is performed at that same edge, and the FSM moves to RESP with rsp_valid=1 in the next cycle. Latency is 1 cycle from acceptance to rsp_valid.
  - RESP: req_ready=0. rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1, then the FSM returns to IDLE. A new request is accepted no earlier than the cycle after the handshake (no back-to-back overlap).
- Read data is sampled at the acceptance edge. An mtime read returns the value before any increment at that edge.
- Timebase:
  - The prescaler counts 0..TICK_DIV-1. tick=1 when prescaler==TICK_DIV-1, after which the prescaler wraps to 0.
  - TICK_DIV=1 gives tick every cycle.
  - On tick, mtime = mtime+1, modulo 2^64 (FFFF_FFFF_FFFF_FFFF wraps to 0).
- Simultaneous events:
  - A bus write to mtime at the tick edge wins: the written bytes replace mtime and the tick increment is discarded for that cycle. Bytes that are not written are also not incremented.
  - The prescaler continues counting regardless of bus writes.
- mtip_asyn is registered: next value = (mtime_next >= mtimecmp_next), unsigned, computed from the post-update values. It updates the cycle after the event that causes it and stays level-sensitive until software rewrites mtimecmp or mtime.
- msip_asyn is registered: it equals msip bit0, with a one-cycle delay after the write edge.

Test Plan:
- Reset, then read 0xBFF8 with TICK_DIV=1 on the first IDLE cycle -> rsp_valid next cycle, rsp_rdata=0, rsp_err=0; read 0x4000 -> FFFF_FFFF_FFFF_FFFF; mtip_asyn=0.
- TICK_DIV=4; after 40 clk cycles, read mtime -> 10 (±1 depending on sampling edge, checked exactly against the model).
- Write mtimecmp=20 (wstrb=FF), TICK_DIV=1 -> mtip_asyn rises in the cycle after mtime reaches 20; then write mtimecmp=FFFF_FFFF_FFFF_FFFF -> mtip_asyn=0 one cycle after the write edge.
- Write 0x0000 data=3, wstrb=01 -> msip_asyn=1 next cycle, read back 1. Write data=0 -> msip_asyn=0.
- Write mtime=FFFF_FFFF_FFFF_FFFE with wstrb=FF exactly on a tick edge -> after 2 further ticks mtime=0 (write won, then wrap); mtip holds for mtimecmp=0.
- Access 0x0004 -> rsp_err=1, rdata=0, no state change. Access 0x2000 -> rsp_err=1. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable and req_ready=0 throughout. Assert rst_n low during RESP -> rsp_valid=0 immediately.
